// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: controller states, register-zero constant,
// bubble control word and the stage-control patterns driven by pipeline_ctrl.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control fields carried by the ID/EX pipeline register; a bubble is all zeros.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       halt;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = ctrl_t'(12'd0);

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_ADVANCE  = stage_ctl_t'(8'b11111_000);
    localparam stage_ctl_t CTL_FREEZE   = stage_ctl_t'(8'b00000_000);
    localparam stage_ctl_t CTL_MEM_WAIT = stage_ctl_t'(8'b00001_001);
    localparam stage_ctl_t CTL_SQUASH   = stage_ctl_t'(8'b11111_110);
    localparam stage_ctl_t CTL_LOAD_USE = stage_ctl_t'(8'b00111_010);
    // Front end starved while older instructions (including HALT) retire.
    localparam stage_ctl_t CTL_DRAIN    = stage_ctl_t'(8'b01111_100);

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX writes a register the ID instruction reads.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    assign rs1_hit_s = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit_s = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is never a real dependency, so loads into it never stall.
    assign load_use  = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt controller for the five-stage pipeline: combinational
// stage controls from state and hazards, registered state and counters.
module pipeline_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_halt,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    ctrl_state_t       state_r;
    logic [WCNT_W-1:0] wcnt_r;
    logic              mem_err_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic       load_use_s;
    logic       active_s;
    logic       mem_stall_s;
    logic       timeout_s;
    logic       branch_s;
    logic       lu_stall_s;
    logic       halt_go_s;
    stage_ctl_t ctl_s;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_memRead),
        .ex_rd       (ex_rd),
        .load_use    (load_use_s)
    );

    // Qualify raw hazards by state and priority; each flag is the effective event.
    always_comb begin
        active_s    = (state_r == RUN) || (state_r == DRAIN);
        mem_stall_s = active_s && mem_req && !mem_ready;
        timeout_s   = mem_stall_s && (wcnt_r == WCNT_LAST);
        branch_s    = (state_r == RUN) && !mem_stall_s && ex_branch_taken;
        lu_stall_s  = (state_r == RUN) && !mem_stall_s && !ex_branch_taken && load_use_s;
        halt_go_s   = (state_r == RUN) && !mem_stall_s && !ex_branch_taken && !load_use_s && id_halt;
    end

    // Stage control selection; a timeout freezes everything in the same cycle.
    always_comb begin
        ctl_s = CTL_FREEZE;
        case (state_r)
            RUN, DRAIN: begin
                if (timeout_s) begin
                    ctl_s = CTL_FREEZE;
                end else if (mem_stall_s) begin
                    ctl_s = CTL_MEM_WAIT;
                end else if (state_r == DRAIN) begin
                    ctl_s = CTL_DRAIN;
                end else if (branch_s) begin
                    ctl_s = CTL_SQUASH;
                end else if (lu_stall_s) begin
                    ctl_s = CTL_LOAD_USE;
                end else begin
                    ctl_s = CTL_ADVANCE;
                end
            end
            HALTED:  ctl_s = CTL_FREEZE;
            default: ctl_s = CTL_FREEZE;
        endcase
    end

    assign pc_en         = ctl_s.pc_en;
    assign if_id_en      = ctl_s.if_id_en;
    assign id_ex_en      = ctl_s.id_ex_en;
    assign ex_mem_en     = ctl_s.ex_mem_en;
    assign mem_wb_en     = ctl_s.mem_wb_en;
    assign if_id_flush   = ctl_s.if_id_flush;
    assign id_ex_flush   = ctl_s.id_ex_flush;
    assign mem_wb_bubble = ctl_s.mem_wb_bubble;
    assign halted        = (state_r == HALTED);
    assign mem_err       = mem_err_r;
    assign stall_cnt     = stall_cnt_r;
    assign flush_cnt     = flush_cnt_r;

    // Controller state: halt entry, drain completion and memory-timeout lockup.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (timeout_s) begin
                        state_r <= HALTED;
                    end else if (halt_go_s) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DRAIN: begin
                    if (timeout_s || wb_halt) begin
                        state_r <= HALTED;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                HALTED:  state_r <= HALTED;
                default: state_r <= RUN;
            endcase
        end
    end

    // Consecutive memory wait cycles and the sticky timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt_r    <= {WCNT_W{1'b0}};
            mem_err_r <= 1'b0;
        end else begin
            if (mem_stall_s) begin
                wcnt_r <= wcnt_r + WCNT_W'(1);
            end else begin
                wcnt_r <= {WCNT_W{1'b0}};
            end
            mem_err_r <= mem_err_r | timeout_s;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if ((mem_stall_s || lu_stall_s) && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (branch_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random
// stimulus, both compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam int MT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, id_halt, ex_memRead;
    logic          ex_branch_taken, mem_req, mem_ready, wb_halt;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, mem_wb_bubble, halted, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit m_halted, m_drain, m_err;
    int m_wait, m_stalls, m_flushes;

    pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_halt(id_halt), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .wb_halt(wb_halt),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .halted(halted), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_halted = 1'b0; m_drain = 1'b0; m_err = 1'b0;
        m_wait = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_halt = 1'b0;
        ex_memRead = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1; wb_halt = 1'b0;
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Called at a negedge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        bit mstall, to, lu, br;
        logic [7:0] exp_ctl;
        if (reset) model_clear();
        #1;
        mstall = !m_halted && mem_req && !mem_ready;
        to     = mstall && (m_wait + 1 >= MT);
        lu     = ex_memRead && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        br     = ex_branch_taken;
        // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, bubble}
        if (m_halted || to)   exp_ctl = 8'b00000_000;
        else if (mstall)      exp_ctl = 8'b00001_001;
        else if (m_drain)     exp_ctl = 8'b01111_100;
        else if (br)          exp_ctl = 8'b11111_110;
        else if (lu)          exp_ctl = 8'b00111_010;
        else                  exp_ctl = 8'b11111_000;
        check("ctl", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                          if_id_flush, id_ex_flush, mem_wb_bubble}), 32'(exp_ctl));
        check("halted", 32'(halted), 32'(m_halted));
        check("mem_err", 32'(mem_err), 32'(m_err));
        check("stall_cnt", 32'(stall_cnt), 32'(sat(m_stalls)));
        check("flush_cnt", 32'(flush_cnt), 32'(sat(m_flushes)));
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else if (!m_halted) begin
            if (mstall || (!m_drain && !br && lu)) m_stalls++;
            if (!mstall && !m_drain && br) m_flushes++;
            m_wait = mstall ? m_wait + 1 : 0;
            if (to) begin
                m_err = 1'b1; m_halted = 1'b1;
            end else if (m_drain && wb_halt) begin
                m_halted = 1'b1;
            end else if (!m_drain && !mstall && !br && !lu && id_halt) begin
                m_drain = 1'b1;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic load_use_stim();
        ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    initial begin
        int bias;
        reset = 1'b1;
        set_idle();
        model_clear();
        @(negedge clock);
        do_reset();

        // load-use: one stall cycle, then no stall when the load targets x0
        load_use_stim(); cycle();
        set_idle(); cycle();
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; cycle();
        set_idle();
        check("lu_x0_no_stall", 32'(stall_cnt), 32'd1);

        // taken branch wins over a simultaneous load-use
        load_use_stim(); ex_branch_taken = 1'b1; cycle();
        set_idle();
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd1);

        // memory wait of three cycles, released when ready
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) cycle();
        mem_ready = 1'b1; cycle();
        set_idle();
        check("mem_wait_stall_cnt", 32'(stall_cnt), 32'd3);

        // halt drain: wb_halt three cycles after id_halt
        do_reset();
        id_halt = 1'b1; cycle();
        id_halt = 1'b0; cycle(); cycle();
        wb_halt = 1'b1; cycle();
        wb_halt = 1'b0;
        check("drain_halted", 32'(halted), 32'd1);
        check("drain_pc_en", 32'(pc_en), 32'd0);
        cycle();

        // timeout after MT wait cycles, cleared by reset
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (MT) cycle();
        check("timeout_mem_err", 32'(mem_err), 32'd1);
        check("timeout_halted", 32'(halted), 32'd1);
        cycle();
        do_reset();
        check("reset_mem_err", 32'(mem_err), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);

        // stall counter saturation
        load_use_stim();
        repeat (20) cycle();
        set_idle();
        check("stall_saturate", 32'(stall_cnt), 32'd15);

        // randomized traffic, with occasional resets to escape HALTED
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bias            = (i / 250) % 3;
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_memRead      = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req         = ($urandom_range(0, 2) != 0);
            mem_ready       = ($urandom_range(0, 3) >= bias);
            id_halt         = ($urandom_range(0, 19) == 0);
            wb_halt         = ($urandom_range(0, 3) == 0);
            reset           = ($urandom_range(0, 39) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush/halt controller for the five-stage RISC-V pipeline. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch squashes and data-memory wait states. It sequences the halt drain so that the halt instruction retires through writeback before the core freezes.

## Interface
- MEM_TIMEOUT, 64: maximum consecutive cycles a data-memory request may wait before an error.
- CNT_W, 16: width of the performance counters.

- clock  in  1  pipeline clock.
- reset  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1 / rs2.
- id_halt  in  1  instruction in ID is HALT.
- ex_memRead  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_halt  in  1  halt flag at the MEM/WB output.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage load enables.
- if_id_flush, id_ex_flush  out  1  load a bubble (all controls 0) instead of data.
- mem_wb_bubble  out  1  load a bubble into MEM/WB.
- halted  out  1  core frozen after HALT retired.
- mem_err  out  1  memory timeout occurred (sticky).
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

## Operation
- States: RUN, DRAIN, HALTED. A separate wait counter wcnt (width clog2(MEM_TIMEOUT+1)) tracks memory stalls.
- Outputs are combinational from state and inputs. State and counters are registered.
- Conditions are evaluated by priority:
  - **Memory stall** (mem_req && !mem_ready), RUN or DRAIN: pc_en = if_id_en = id_ex_en = ex_mem_en = 0; mem_wb_en = 1 with mem_wb_bubble = 1; flushes 0; wcnt increments.
  - **Taken branch** (ex_branch_taken, no memory stall): all enables 1; if_id_flush = id_ex_flush = 1. Any simultaneous load-use or id_halt is ignored, because the ID instruction is squashed.
  - **Load-use** (ex_memRead && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd))): pc_en = if_id_en = 0; id_ex_flush = 1; remaining enables 1. Exactly one bubble is inserted per load.
  - **Otherwise**: all enables 1 and no flushes.
- **Halt entry:** in RUN, id_halt with no memory stall, taken branch or load-use moves the state to DRAIN at the next edge. The HALT instruction itself advances normally.
- **DRAIN:** pc_en = 0; if_id_flush = 1; downstream stages advance, subject to memory stall. When wb_halt = 1, the state moves to HALTED.
- **HALTED:** all enables 0, flushes 0, halted = 1. Only reset exits this state.
- **Timeout:** if wcnt reaches MEM_TIMEOUT while the memory stall persists, mem_err is set, the state moves to HALTED, and all enables drop to 0. wcnt clears on any cycle without a memory stall.
- **stall_cnt** increments on every cycle in RUN or DRAIN with a memory stall or load-use stall active.
- **flush_cnt** increments on every taken-branch cycle.
- Both counters saturate at 2^CNT_W − 1.

## Timing
- Reset values: state = RUN, wcnt = 0, halted = 0, mem_err = 0, stall_cnt = flush_cnt = 0.
- Asserting reset mid-stall or mid-drain returns the block to RUN on the same edge. Outputs then follow the RUN rules combinationally.
- Stall and flush decisions take zero cycles: they apply in the same cycle the condition is present.
- A memory access with mem_ready = 1 on its first cycle causes no stall. Each wait cycle adds exactly one stall cycle.
- The timeout asserts on the cycle in which MEM_TIMEOUT consecutive wait cycles have elapsed. mem_err is visible from the next cycle onward.
- Halt drain: HALT reaches WB after 3 advancing cycles plus any memory stall cycles. halted rises 1 cycle after wb_halt.

## Structure
- The shared package riscv_pkg holds:
  - the ctrl_state_t enum (RUN, DRAIN, HALTED);
  - REG_ZERO = 5'd0;
  - the bubble control encoding (all control fields 0).
- One sub-module, hazard_detect, is a combinational load-use comparator producing a load_use output. It is instantiated once.

## Test plan
- **Load-use:** ex_memRead = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 → one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; stall_cnt = 1. With ex_rd = 0 there is no stall.
- **Branch beats load-use:** ex_branch_taken = 1 in the same cycle as a load-use match → if_id_flush = id_ex_flush = 1, pc_en = 1; flush_cnt = 1, stall_cnt unchanged.
- **Memory wait:** mem_req = 1, mem_ready low for 3 cycles → 3 cycles of frozen stages with mem_wb_bubble = 1; release in the mem_ready cycle; stall_cnt = 3.
- **Halt drain:** id_halt pulse → DRAIN with pc_en = 0; wb_halt asserted 3 cycles later → halted = 1 the following cycle, all enables 0.
- **Timeout:** mem_req = 1 with mem_ready = 0 for MEM_TIMEOUT = 4 cycles → mem_err = 1 and halted = 1. Asserting reset then clears both and returns the state to RUN.
- **Saturation:** with CNT_W = 4 and 20 load-use stalls → stall_cnt = 15.
